// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result handshake bundle for the multiply/divide unit.
// The core pipeline drives the master side; muldiv_unit implements the slave.
interface muldiv_unit_if;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  operation;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output op_valid, operation, operand_a, operand_b, result_ready,
        input  op_ready, result_valid, result, busy
    );

    modport slave (
        input  op_valid, operation, operand_a, operand_b, result_ready,
        output op_ready, result_valid, result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative RV32M multiply/divide (32 CALC cycles).
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic        mul_q, mul_d;
    logic        sel_q, sel_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;

    logic        dec_mul, dec_div, dec_sel, dec_sa, dec_sb;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    always_comb begin
        dec_mul = 1'b0;
        dec_div = 1'b0;
        dec_sel = 1'b0;
        dec_sa  = 1'b0;
        dec_sb  = 1'b0;
        case (bus.operation)
            OP_MUL:    dec_mul = 1'b1;
            OP_MULH: begin
                dec_mul = 1'b1;
                dec_sel = 1'b1;
                dec_sa  = 1'b1;
                dec_sb  = 1'b1;
            end
            OP_MULHSU: begin
                dec_mul = 1'b1;
                dec_sel = 1'b1;
                dec_sa  = 1'b1;
            end
            OP_MULHU: begin
                dec_mul = 1'b1;
                dec_sel = 1'b1;
            end
            OP_DIV: begin
                dec_div = 1'b1;
                dec_sa  = 1'b1;
                dec_sb  = 1'b1;
            end
            OP_DIVU:   dec_div = 1'b1;
            OP_REM: begin
                dec_div = 1'b1;
                dec_sel = 1'b1;
                dec_sa  = 1'b1;
                dec_sb  = 1'b1;
            end
            OP_REMU: begin
                dec_div = 1'b1;
                dec_sel = 1'b1;
            end
            default: ;
        endcase
    end

    assign a_neg = dec_sa & bus.operand_a[31];
    assign b_neg = dec_sb & bus.operand_b[31];
    assign a_mag = a_neg ? (~bus.operand_a + 32'd1) : bus.operand_a;
    assign b_mag = b_neg ? (~bus.operand_b + 32'd1) : bus.operand_b;

    // One radix-2 step; hi holds the partial product or running remainder.
    logic [32:0] msum;
    logic [32:0] dshift;
    logic        dge;
    logic [31:0] drem;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix, fin;

    assign msum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    assign dshift  = {hi_q, lo_q[31]};
    assign dge     = dshift >= {1'b0, b_q};
    assign drem    = dge ? (dshift[31:0] - b_q) : dshift[31:0];
    assign step_hi = mul_q ? msum[32:1] : drem;
    assign step_lo = mul_q ? {msum[0], lo_q[31:1]} : {lo_q[30:0], dge};

    assign prod     = {step_hi, step_lo};
    assign prod_fix = negq_q ? (~prod + 64'd1) : prod;
    assign quo_fix  = negq_q ? (~step_lo + 32'd1) : step_lo;
    assign rem_fix  = negr_q ? (~step_hi + 32'd1) : step_hi;
    assign fin      = mul_q ? (sel_q ? prod_fix[63:32] : prod_fix[31:0])
                            : (sel_q ? rem_fix : quo_fix);

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fa, fb, fprod;
    assign fa    = {{32{dec_sa & bus.operand_a[31]}}, bus.operand_a};
    assign fb    = {{32{dec_sb & bus.operand_b[31]}}, bus.operand_b};
    assign fprod = fa * fb;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        res_d   = res_q;
        mul_d   = mul_q;
        sel_d   = sel_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    mul_d  = dec_mul;
                    sel_d  = dec_sel;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    if (!(dec_mul || dec_div)) begin
                        res_d   = 32'h0;
                        state_d = DONE;
                    end else if (dec_div && bus.operand_b == 32'h0) begin
                        res_d   = dec_sel ? bus.operand_a : 32'hFFFF_FFFF;
                        state_d = DONE;
                    end else if (dec_div && dec_sa &&
                                 bus.operand_a == 32'h8000_0000 &&
                                 bus.operand_b == 32'hFFFF_FFFF) begin
                        res_d   = dec_sel ? 32'h0 : 32'h8000_0000;
                        state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (dec_mul) begin
                        res_d   = dec_sel ? fprod[63:32] : fprod[31:0];
                        state_d = DONE;
`endif
                    end else begin
                        hi_d    = 32'h0;
                        lo_d    = a_mag;
                        b_d     = b_mag;
                        cnt_d   = 5'd0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    res_d   = fin;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            b_q     <= 32'h0;
            res_q   <= 32'h0;
            mul_q   <= 1'b0;
            sel_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            res_q   <= res_d;
            mul_q   <= mul_d;
            sel_q   <= sel_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign bus.op_ready     = (state_q == IDLE) && !rst;
    assign bus.result_valid = (state_q == DONE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.result       = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Latencies counted in clocks from the accept edge to result_valid seen.
module tb_muldiv_unit;
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    muldiv_unit_if bus ();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] model(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int          sa, sb, q;
        logic [63:0] p;
        logic [63:0] ua, ub;
        sa = a;
        sb = b;
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            OP_MUL: begin
                p = longint'(sa) * longint'(sb);
                return p[31:0];
            end
            OP_MULH: begin
                p = longint'(sa) * longint'(sb);
                return p[63:32];
            end
            OP_MULHSU: begin
                p = longint'(sa) * longint'(ub);
                return p[63:32];
            end
            OP_MULHU: begin
                p = ua * ub;
                return p[63:32];
            end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb;
                return q;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                q = sa % sb;
                return q;
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (op >= OP_MUL && op <= OP_MULHU) return MUL_LAT;
        if (op >= OP_DIV && op <= OP_REMU) begin
            if (b == 0) return 1;
            if ((op == OP_DIV || op == OP_REM) &&
                a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int k = 0;
        @(negedge clk);
        while (!bus.op_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        bus.op_valid  = 1'b1;
        bus.operation = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [31:0] r, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.result_valid && lat < 200);
        if (!bus.result_valid) lat = -1;
        r = bus.result;
    endtask

    task automatic take_result();
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1 bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.op_valid = 1'b0;
        bus.result_ready = 1'b0;
        bus.operation = 5'd0;
        bus.operand_a = 32'd0;
        bus.operand_b = 32'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.op_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_op_ready_in_rst: got %b expected 0", bus.op_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.op_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_op_ready: got %b expected 1", bus.op_ready);
        end
        n_cmp++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: valid %b busy %b expected 0 0",
                     bus.result_valid, bus.busy);
        end
        n_cmp++;
        if (bus.result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_result: got %h expected 00000000", bus.result);
        end
    endtask

    task automatic test_mul();
        logic [4:0]  ops[4] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU};
        logic [31:0] as[4]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] er[4]  = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] r;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            sb_q.push_back('{er[i], MUL_LAT});
            wait_result(r, lat);
            e = sb_q.pop_front();
            n_cmp++;
            if (r !== e.res) begin
                n_bad++;
                $display("FAIL mul[%0d] result: got %h expected %h", i, r, e.res);
            end
            n_cmp++;
            if (lat !== e.lat) begin
                n_bad++;
                $display("FAIL mul[%0d] latency: got %0d expected %0d", i, lat, e.lat);
            end
            take_result();
        end
    endtask

    task automatic test_div();
        logic [4:0]  ops[6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[6]  = '{32'd2, 32'd2, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] er[6]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100,
                                32'h8000_0000, 32'h0};
        int          el[6]  = '{33, 33, 1, 1, 1, 1};
        logic [31:0] r;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            sb_q.push_back('{er[i], el[i]});
            wait_result(r, lat);
            e = sb_q.pop_front();
            n_cmp++;
            if (r !== e.res) begin
                n_bad++;
                $display("FAIL div[%0d] result: got %h expected %h", i, r, e.res);
            end
            n_cmp++;
            if (lat !== e.lat) begin
                n_bad++;
                $display("FAIL div[%0d] latency: got %0d expected %0d", i, lat, e.lat);
            end
            take_result();
        end
    endtask

    task automatic test_invalid();
        logic [4:0]  ops[4] = '{5'b00000, 5'b01001, 5'b10010, 5'b11111};
        logic [31:0] r;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 32'h1234_5678, 32'h9ABC_DEF0);
            sb_q.push_back('{32'h0, 1});
            wait_result(r, lat);
            e = sb_q.pop_front();
            n_cmp++;
            if (r !== e.res || lat !== e.lat) begin
                n_bad++;
                $display("FAIL invalid[%0d]: got %h lat %0d expected %h lat %0d",
                         i, r, lat, e.res, e.lat);
            end
            take_result();
        end
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] a, b, r;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 16; i++) begin
            op = 5'(10 + $urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 5) == 0) b = 32'h0;
            if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFFF - ($urandom & 32'hF);
            issue(op, a, b);
            sb_q.push_back('{model(op, a, b), exp_lat(op, a, b)});
            wait_result(r, lat);
            e = sb_q.pop_front();
            n_cmp++;
            if (r !== e.res || lat !== e.lat) begin
                n_bad++;
                $display("FAIL rand[%0d] op %b a %h b %h: got %h lat %0d expected %h lat %0d",
                         i, op, a, b, r, lat, e.res, e.lat);
            end
            take_result();
        end
    endtask

    task automatic test_stall();
        logic [31:0] r;
        int          lat;
        exp_t        e;
        issue(OP_DIVU, 32'd50, 32'd7);
        sb_q.push_back('{32'd7, 33});
        wait_result(r, lat);
        e = sb_q.pop_front();
        n_cmp++;
        if (r !== e.res || lat !== e.lat) begin
            n_bad++;
            $display("FAIL stall_first: got %h lat %0d expected %h lat %0d",
                     r, lat, e.res, e.lat);
        end
        bus.op_valid  = 1'b1;
        bus.operation = OP_MULHU;
        bus.operand_a = 32'hFFFF_FFFF;
        bus.operand_b = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.result !== e.res || bus.result_valid !== 1'b1 ||
                bus.op_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: result %h valid %b ready %b expected %h 1 0",
                         i, bus.result, bus.result_valid, bus.op_ready, e.res);
            end
        end
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1 bus.result_ready = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.op_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_take_edge: busy %b ready %b expected 0 1",
                     bus.busy, bus.op_ready);
        end
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        sb_q.push_back('{32'hFFFF_FFFE, MUL_LAT});
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_accept_next: busy %b expected 1", bus.busy);
        end
        wait_result(r, lat);
        e = sb_q.pop_front();
        n_cmp++;
        if (r !== e.res || lat !== e.lat) begin
            n_bad++;
            $display("FAIL stall_second: got %h lat %0d expected %h lat %0d",
                     r, lat, e.res, e.lat);
        end
        take_result();
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        int          lat;
        exp_t        e;
        logic        seen = 1'b0;
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.op_ready !== 1'b0 || bus.result_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.result !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_in_rst: ready %b valid %b busy %b result %h expected 0 0 0 0",
                     bus.op_ready, bus.result_valid, bus.busy, bus.result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.result_valid || bus.busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || bus.op_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_no_result: activity %b ready %b expected 0 1",
                     seen, bus.op_ready);
        end
        issue(OP_DIVU, 32'd9, 32'd4);
        sb_q.push_back('{32'd2, 33});
        wait_result(r, lat);
        e = sb_q.pop_front();
        n_cmp++;
        if (r !== e.res || lat !== e.lat) begin
            n_bad++;
            $display("FAIL abort_recover: got %h lat %0d expected %h lat %0d",
                     r, lat, e.res, e.lat);
        end
        take_result();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_invalid();
        test_stall();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port op_valid, input, 1, request present.
REQ-004 SHALL have port op_ready, output, 1, unit can accept a request.
REQ-005 SHALL have port operation, input, 5, ALU operation code: MUL 5'b01010, MULH 5'b01011, MULHSU 5'b01100, MULHU 5'b01101, DIV 5'b01110, DIVU 5'b01111, REM 5'b10000, REMU 5'b10001.
REQ-006 SHALL have port operand_a, input, 32, rs1 value (multiplicand or dividend).
REQ-007 SHALL have port operand_b, input, 32, rs2 value (multiplier or divisor).
REQ-008 SHALL have port result_valid, output, 1, result available.
REQ-009 SHALL have port result_ready, input, 1, consumer takes result.
REQ-010 SHALL have port result, output, 32, registered result.
REQ-011 SHALL have port busy, output, 1, high in CALC or DONE.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE; op_ready = (state==IDLE) and not rst.
REQ-013 SHALL accept on the rising edge where op_valid and op_ready are both high, registering operation and operands; inputs are ignored at all other times.
REQ-014 SHALL, for codes outside 5'b01010..5'b10001, accept the request, go directly to DONE and return result 32'h0000_0000.
REQ-015 SHALL, for signed operands (MULH: both; MULHSU: a only; DIV/REM: both), convert to magnitudes at accept and apply sign correction on the CALC-to-DONE transition.
REQ-016 SHALL iterate radix-2 (shift-add for multiply, restoring shift-subtract for divide) for exactly 32 CALC cycles, tracked by a 5-bit counter that wraps 31->0 on the final cycle.
REQ-017 SHALL produce 64-bit products; MUL returns bits [31:0], MULH/MULHSU/MULHU bits [63:32].
REQ-018 SHALL assert result_valid from the cycle after the 32nd CALC cycle: 33 cycles after the accept edge.
REQ-019 SHALL, for divisor zero, go directly to DONE (result_valid 1 cycle after accept): DIV/DIVU return 32'hFFFF_FFFF, REM/REMU return operand_a.
REQ-020 SHALL, for DIV with operand_a 32'h8000_0000 and operand_b 32'hFFFF_FFFF, go directly to DONE returning 32'h8000_0000; REM in the same case returns 32'h0.
REQ-021 SHALL hold result and result_valid stable in DONE until result_ready is high, then return to IDLE on that edge.
REQ-022 SHALL keep op_ready low in DONE, so a new request is never accepted in the same cycle a result is taken.
REQ-023 SHALL ignore result_ready outside DONE.

Reset
REQ-024 SHALL on rst asynchronously force state IDLE, counter 0, result 32'h0, result_valid 0, busy 0, and all operand/accumulator registers 0.
REQ-025 SHALL abort any operation in flight on rst with no result delivered; op_ready rises after rst deasserts.

Configuration
REQ-026 SHALL, with macro MULDIV_FAST_MUL_EN defined, compute MUL/MULH/MULHSU/MULHU with a single-cycle combinational multiplier, going IDLE->DONE with result_valid 1 cycle after accept.
REQ-027 SHALL, without MULDIV_FAST_MUL_EN, use the 32-cycle iterative multiplier per REQ-016/REQ-018; divide behaviour is identical in both builds.

Verification
REQ-028 SHALL cover MUL a=7, b=-3 (32'hFFFF_FFFD) -> result 32'hFFFF_FFEB, result_valid at accept+33 (accept+1 with MULDIV_FAST_MUL_EN).
REQ-029 SHALL cover MULHU a=b=32'hFFFF_FFFF -> 32'hFFFF_FFFE; MULH same operands -> 32'h0; MULHSU a=32'hFFFF_FFFF, b=2 -> 32'hFFFF_FFFF.
REQ-030 SHALL cover DIV a=-7, b=2 -> 32'hFFFF_FFFD; REM same -> 32'hFFFF_FFFF; DIVU a=100, b=0 -> 32'hFFFF_FFFF at accept+1; REMU a=100, b=0 -> 100.
REQ-031 SHALL cover DIV a=32'h8000_0000, b=-1 -> 32'h8000_0000 at accept+1; REM same -> 0.
REQ-032 SHALL cover result_ready held low 10 cycles in DONE -> result and result_valid stable; op_valid high throughout -> op_ready low and no accept until the cycle after result_ready.
REQ-033 SHALL cover rst pulse at CALC cycle 15 of DIVU -> result_valid never asserts, all outputs at reset values, and a new DIVU 9/4 afterwards returns 2 at accept+33.
